// File: rtl/mod_exp_io_pkg.sv
// Shared types and operand slot layout for the modular-exponentiation stream front end.
package mod_exp_io_pkg;

    localparam int unsigned CONFIG_DATA_WIDTH = 256;

    typedef enum logic [1:0] {
        StLoad,
        StIssue,
        StWait,
        StUnload
    } state_e;

    // Operand slot order on the input stream; each slot spans NWORDS words.
    localparam int unsigned SLOT_C    = 0;
    localparam int unsigned SLOT_D    = 1;
    localparam int unsigned SLOT_R2   = 2;
    localparam int unsigned SLOT_N    = 3;
    localparam int unsigned SLOT_TSUB = 4;

    function automatic int unsigned slot_base(input int unsigned slot, input int unsigned nwords);
        return slot * nwords;
    endfunction

endpackage

// File: rtl/mod_exp_io_ctrl.sv
// Word-serial loader/unloader around the modular exponentiation core: gathers operands,
// issues start, waits for done and streams the result back out.
module mod_exp_io_ctrl
    import mod_exp_io_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = CONFIG_DATA_WIDTH,
    parameter int unsigned WORD_WIDTH = 32
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_ce,
    input  logic                          i_in_valid,
    input  logic [WORD_WIDTH-1:0]         i_in_data,
    output logic                          o_in_ready,
    output logic                          o_out_valid,
    output logic [WORD_WIDTH-1:0]         o_out_data,
    input  logic                          i_out_ready,
    output logic                          o_busy,
    output logic                          o_exp_start,
    output logic [DATA_WIDTH-1:0]         o_exp_c,
    output logic [DATA_WIDTH-1:0]         o_exp_d,
    output logic [DATA_WIDTH-1:0]         o_exp_r2_mod_n,
    output logic [DATA_WIDTH-1:0]         o_exp_n,
    output logic [$clog2(DATA_WIDTH)-1:0] o_exp_t_sub_1,
    input  logic                          i_exp_ready,
    input  logic                          i_exp_done,
    input  logic [DATA_WIDTH-1:0]         i_exp_m
);

    localparam int unsigned NWORDS = DATA_WIDTH / WORD_WIDTH;
    localparam int unsigned NOPW   = 4 * NWORDS;
    localparam int unsigned CW     = $clog2(NOPW + 1);
    localparam int unsigned TW     = $clog2(DATA_WIDTH);

    localparam logic [CW-1:0] LAST_IN  = CW'(NOPW);
    localparam logic [CW-1:0] LAST_OUT = CW'(NWORDS - 1);

    state_e                r_state;
    logic [CW-1:0]         r_cnt;
    logic [WORD_WIDTH-1:0] r_op  [NOPW];
    logic [WORD_WIDTH-1:0] r_res [NWORDS];
    logic [TW-1:0]         r_tsub;
    logic                  r_start;
    logic [WORD_WIDTH-1:0] w_out_word;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= StLoad;
            r_cnt   <= '0;
            r_tsub  <= '0;
            r_start <= 1'b0;
            for (int i = 0; i < NOPW; i++) r_op[i] <= '0;
            for (int j = 0; j < NWORDS; j++) r_res[j] <= '0;
        end else if (i_ce) begin
            case (r_state)
                StLoad: begin
                    if (i_in_valid) begin
                        for (int i = 0; i < NOPW; i++) begin
                            if (r_cnt == CW'(i)) r_op[i] <= i_in_data;
                        end
                        if (r_cnt == LAST_IN) begin
                            r_tsub  <= i_in_data[TW-1:0];
                            r_cnt   <= '0;
                            r_state <= StIssue;
                            // Launch straight away when the core is already ready.
                            r_start <= i_exp_ready;
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                end
                StIssue: begin
                    if (r_start) begin
                        r_start <= 1'b0;
                        r_state <= StWait;
                    end else begin
                        r_start <= i_exp_ready;
                    end
                end
                StWait: begin
                    if (i_exp_done) begin
                        for (int j = 0; j < NWORDS; j++) begin
                            r_res[j] <= i_exp_m[j*WORD_WIDTH +: WORD_WIDTH];
                        end
                        r_state <= StUnload;
                    end
                end
                StUnload: begin
                    if (i_out_ready) begin
                        if (r_cnt == LAST_OUT) begin
                            r_cnt   <= '0;
                            r_state <= StLoad;
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                end
                default: r_state <= StLoad;
            endcase
        end
    end

    always_comb begin
        w_out_word = '0;
        for (int j = 0; j < NWORDS; j++) begin
            if (r_cnt == CW'(j)) w_out_word = r_res[j];
        end
    end

    for (genvar k = 0; k < NWORDS; k++) begin : g_op
        assign o_exp_c[k*WORD_WIDTH +: WORD_WIDTH]        = r_op[slot_base(SLOT_C, NWORDS) + k];
        assign o_exp_d[k*WORD_WIDTH +: WORD_WIDTH]        = r_op[slot_base(SLOT_D, NWORDS) + k];
        assign o_exp_r2_mod_n[k*WORD_WIDTH +: WORD_WIDTH] = r_op[slot_base(SLOT_R2, NWORDS) + k];
        assign o_exp_n[k*WORD_WIDTH +: WORD_WIDTH]        = r_op[slot_base(SLOT_N, NWORDS) + k];
    end

    assign o_exp_t_sub_1 = r_tsub;
    assign o_exp_start   = r_start;
    assign o_in_ready    = (r_state == StLoad);
    assign o_out_valid   = (r_state == StUnload);
    assign o_out_data    = w_out_word;
    assign o_busy        = !((r_state == StLoad) && (r_cnt == '0));

endmodule

// File: doc/mod_exp_io_ctrl.md
# mod_exp_io_ctrl

Word-serial front end for the modular exponentiation core: it collects operands over a narrow ready/valid input stream, holds them on the core's wide operand ports, and issues `start`. It then waits for `done`, captures `m`, and returns the result over a narrow ready/valid output stream. It sits directly upstream and downstream of the isolation-capable exponentiation wrapper and drives that wrapper's `start`, `c`, `d`, `t_sub_1`, `r2_mod_n` and `n` inputs.

## Interface
- `DATA_WIDTH`, default `CONFIG_DATA_WIDTH`: operand and result width in bits.
- `WORD_WIDTH`, default 32: stream word width. `DATA_WIDTH` must be an integer multiple of `WORD_WIDTH`. `NWORDS = DATA_WIDTH/WORD_WIDTH`.
- `clk  in  1`: single clock; every register is clocked on its rising edge.
- `rst  in  1`: asynchronous, active-high reset.
- `ce  in  1`: clock enable. While low, all state, counters and registers hold.
- `in_valid  in  1`, `in_data  in  WORD_WIDTH`, `in_ready  out  1`: operand input stream.
- `out_valid  out  1`, `out_data  out  WORD_WIDTH`, `out_ready  in  1`: result output stream.
- `busy  out  1`: high in every state except LOAD with word count 0.
- `exp_start  out  1`: start pulse to the core.
- `exp_c`, `exp_d`, `exp_r2_mod_n`, `exp_n`  `out  DATA_WIDTH`: operands to the core.
- `exp_t_sub_1  out  $clog2(DATA_WIDTH)`: exponent length minus 1.
- `exp_ready  in  1`, `exp_done  in  1`, `exp_m  in  DATA_WIDTH`: core status and result.

## Operation
- **States:** LOAD, ISSUE, WAIT, UNLOAD.
- **Reset values:** state LOAD; word counter 0; all operand and result registers 0. Outputs: `exp_start`=0, `in_ready`=1, `out_valid`=0, `busy`=0.
- **Word transfer:** a word moves on an input or output port only when valid, ready and `ce` are all 1 in the same cycle.
- **LOAD, input order:** `4*NWORDS+1` words, least-significant word first within each operand. The order is c, d, r2_mod_n, n, then one word whose low `$clog2(DATA_WIDTH)` bits become `t_sub_1`; its upper bits are ignored. Each accepted word is written into its slot by counter index.
- **LOAD exit:** after the final word is accepted, the counter clears and the state moves to ISSUE.
- **ISSUE:** `in_ready`=0. When `exp_ready`=1, `exp_start` is asserted for exactly one cycle and the state moves to WAIT. If `exp_ready`=0, the block stays in ISSUE with `exp_start`=0.
- **WAIT:** on `exp_done`=1, `exp_m` is captured into the result register and the state moves to UNLOAD.
- **UNLOAD:** `out_valid`=1 and `out_data` is result word[counter], least-significant word first. The counter advances on each transfer. After word `NWORDS-1` is transferred, the counter clears and the state returns to LOAD.
- **Operand stability:** the `exp_*` operand outputs are driven from the operand registers and are not modified outside LOAD. They are stable from `exp_start` through `exp_done`.
- **Ignored inputs:** `exp_done` is ignored outside WAIT, including a `done` coincident with `exp_start`. `in_valid` is ignored outside LOAD.
- **Result hold:** `out_data` holds its value while `out_valid`=1 and `out_ready`=0.
- **Reset mid-operation:** returns the block to LOAD with a partially loaded operand set discarded and any pending result lost. No `exp_start` is issued.

## Timing
- **Start latency:** `exp_start` is high in the cycle after the last input word is accepted, if `exp_ready`=1 then.
- **Result latency:** `out_valid` rises in the cycle after `exp_done` is sampled in WAIT.
- **Throughput:** one word per cycle in both directions under continuous valid/ready.
- `exp_start` is a registered output and `in_ready`/`out_valid` decode from state only; no combinational path exists from any input to any output.
- **`ce` low:** holds `exp_start` at its current registered value; the ISSUE→WAIT transition is taken only on a `ce`-high cycle, so the pulse is exactly one `ce`-enabled cycle.

## Structure
- **Package `mod_exp_io_pkg`:** the state enum typedef and operand slot index constants (C, D, R2, N, TSUB), expressed in words.
- **Single module:** no sub-module is needed. The word counter is `$clog2(4*NWORDS+1)` bits wide and is shared by LOAD and UNLOAD.

## Test plan
Bench parameters: DATA_WIDTH=64, WORD_WIDTH=32 (NWORDS=2, 9 input words). The core is replaced by a stub that asserts `done` 10 cycles after `start`, with `m` = 0xDEADBEEF_01234567.
- **Basic load:** send words 1,0, 3,0, 0x10,0, 0x21,0, 5. Expect `exp_c`=1, `exp_d`=3, `exp_r2_mod_n`=0x10, `exp_n`=0x21, `exp_t_sub_1`=5, and a one-cycle `exp_start` in the cycle after word 9.
- **Result return:** with the load above, expect `out_data` 0x01234567 then 0xDEADBEEF, `out_valid` rising 1 cycle after `done`, then `in_ready`=1.
- **Backpressure and gating:** hold `exp_ready`=0 for 5 cycles; expect no `exp_start`, then a single pulse. Toggle `ce` during LOAD; expect no word accepted while `ce`=0.
- **Output stall:** `out_ready`=0 for 4 cycles; expect `out_data` stable at 0x01234567 and `busy`=1 throughout.
- **Reset mid-load:** assert `rst` after 4 words, then send a full new set; expect only the new operands on `exp_*` and exactly one `exp_start`.
- **Stray done:** pulse `exp_done` during LOAD; expect no state change and `out_valid`=0.
